// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: count modes,
// direction encodings and default widths.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STEP_W = 4;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for the up/down counter.
// All arithmetic is carried at WIDTH+1 bits so that cnt+s and the wrap
// correction (limit+1) can never overflow silently. The caller guarantees
// s <= limit and cnt <= limit.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] limit,
    input  logic             direction,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_val,
    output logic             wrap
);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] lim_x;
    logic [WIDTH:0] modulus;
    logic [WIDTH:0] sum_x;

    // Step up or down, then wrap modulo limit+1 or clamp at the end stops.
    always_comb begin
        cnt_x    = {1'b0, cnt};
        lim_x    = {1'b0, limit};
        modulus  = lim_x + {{WIDTH{1'b0}}, 1'b1};
        sum_x    = cnt_x + s;
        next_val = cnt;
        wrap     = 1'b0;
        if (direction == DIR_UP) begin
            if (sum_x <= lim_x) begin
                next_val = WIDTH'(sum_x);
            end else if (cnt_mode_e'(sat_mode) == CNT_SAT) begin
                next_val = limit;
            end else begin
                next_val = WIDTH'(sum_x - modulus);
                wrap     = 1'b1;
            end
        end else begin
            if (cnt_x >= s) begin
                next_val = WIDTH'(cnt_x - s);
            end else if (cnt_mode_e'(sat_mode) == CNT_SAT) begin
                next_val = '0;
            end else begin
                next_val = WIDTH'(cnt_x + modulus - s);
                wrap     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable limit and step, synchronous
// load, wrap/saturate mode and terminal flags.
// Optional macro COUNTER_PRESCALE_EN adds parameter PRESCALE: a count step
// then happens only on every PRESCALE-th enabled cycle.
// Edge priority: rst, load, out-of-range resync, enabled count, hold.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W,
    // Nominal limit value for integrators; limit itself is always an input.
    parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              direction,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  counter_out,
    output logic              wrap_pulse,
    output logic              at_max,
    output logic              at_min
);

    // Wide enough to compare step and limit without truncating either.
    localparam int CW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [CW-1:0]    step_w;
    logic [CW-1:0]    limit_w;
    logic [CW-1:0]    s_w;
    logic [WIDTH:0]   s_eff;
    logic [WIDTH-1:0] calc_next;
    logic             calc_wrap;
    logic             out_of_range;
    logic             tick;

    // Effective step is clamped to the limit so one step never exceeds a modulus.
    always_comb begin
        step_w  = CW'(step);
        limit_w = CW'(limit);
        s_w     = (step_w < limit_w) ? step_w : limit_w;
        s_eff   = s_w[WIDTH:0];
    end

    assign out_of_range = (cnt_q > limit);

    counter_next_calc #(
        .WIDTH(WIDTH)
    ) u_next_calc (
        .cnt      (cnt_q),
        .s        (s_eff),
        .limit    (limit),
        .direction(direction),
        .sat_mode (sat_mode),
        .next_val (calc_next),
        .wrap     (calc_wrap)
    );

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler counts enabled cycles; load restarts it, resync leaves it alone.
    always_comb begin
        tick = (ps_q == PS_W'(PRESCALE - 1));
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (out_of_range) begin
            ps_d = ps_q;
        end else if (enable) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Edge priority: load, resync to limit, enabled count step, hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > limit) ? limit : load_val;
        end else if (out_of_range) begin
            cnt_d = limit;
        end else if (enable && tick) begin
            cnt_d  = calc_next;
            wrap_d = calc_wrap;
        end
    end

    // Count and wrap-pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign counter_out = cnt_q;
    assign wrap_pulse  = wrap_q;
    assign at_max      = (cnt_q == limit);
    assign at_min      = (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod (WIDTH=8, STEP_W=4): directed vector table,
// hand sequences for reset and prescale, and a randomized run against an
// arithmetic reference model.
module tb_updown_counter_mod;

    localparam int PS = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       direction;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] step;
    logic [7:0] limit;
    logic       sat_mode;
    logic [7:0] counter_out;
    logic       wrap_pulse;
    logic       at_max;
    logic       at_min;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       dir;
        logic [3:0] st;
        logic [7:0] lim;
        logic       sat;
        logic [7:0] exp_cnt;
        logic       exp_wrap;
        logic       exp_max;
        logic       exp_min;
    } vec_t;

    vec_t vec_q[$];

    // reference model state
    int m_cnt;
    int m_wrap;
    int m_ps;

    updown_counter_mod #(
        .WIDTH (8),
        .STEP_W(4)
`ifdef COUNTER_PRESCALE_EN
        ,
        .PRESCALE(PS)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .direction  (direction),
        .load       (load),
        .load_val   (load_val),
        .step       (step),
        .limit      (limit),
        .sat_mode   (sat_mode),
        .counter_out(counter_out),
        .wrap_pulse (wrap_pulse),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] lv, input logic en,
                         input logic dir, input logic [3:0] st, input logic [7:0] lim,
                         input logic sat);
        load      = ld;
        load_val  = lv;
        enable    = en;
        direction = dir;
        step      = st;
        limit     = lim;
        sat_mode  = sat;
    endtask

    task automatic add(input logic ld, input logic [7:0] lv, input logic en,
                       input logic dir, input logic [3:0] st, input logic [7:0] lim,
                       input logic sat, input logic [7:0] ec, input logic ew,
                       input logic emx, input logic emn);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.dir = dir; v.st = st; v.lim = lim;
        v.sat = sat; v.exp_cnt = ec; v.exp_wrap = ew; v.exp_max = emx; v.exp_min = emn;
        vec_q.push_back(v);
    endtask

    // Reference: wrap as modular arithmetic over limit+1, saturate as a clamp.
    task automatic model_step(input int r, input int ld, input int lv, input int en,
                              input int dir, input int st, input int lim, input int sat);
        int s;
        int t;
        int m;
        int fire;
        m_wrap = 0;
        if (r == 0) begin
            m_cnt = 0;
            m_ps  = 0;
        end else if (ld != 0) begin
            m_cnt = (lv < lim) ? lv : lim;
            m_ps  = 0;
        end else if (m_cnt > lim) begin
            m_cnt = lim;
        end else if (en != 0) begin
            fire = 1;
`ifdef COUNTER_PRESCALE_EN
            m_ps = m_ps + 1;
            fire = (m_ps == PS) ? 1 : 0;
            if (fire != 0) m_ps = 0;
`endif
            if (fire != 0) begin
                s = (st < lim) ? st : lim;
                m = lim + 1;
                t = (dir != 0) ? m_cnt + s : m_cnt - s;
                if (sat != 0) begin
                    m_cnt = (t > lim) ? lim : ((t < 0) ? 0 : t);
                end else begin
                    m_cnt  = (t + m) % m;
                    m_wrap = (t >= m || t < 0) ? 1 : 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 4'd0, 8'd255, 1'b0);
        tick();
        tick();
        check("reset_cnt", 32'(counter_out), 32'd0);
        check("reset_wrap", 32'(wrap_pulse), 32'd0);
        check("reset_at_min", 32'(at_min), 32'd1);
        rst = 1'b1;

        // Reset overrides load and enable mid-count.
        drive(1'b1, 8'd37, 1'b0, 1'b1, 4'd1, 8'd255, 1'b0);
        tick();
        check("pre_reset_load", 32'(counter_out), 32'd37);
        rst = 1'b0;
        drive(1'b1, 8'd99, 1'b1, 1'b1, 4'd1, 8'd255, 1'b0);
        tick();
        rst = 1'b1;
        check("midcount_reset_cnt", 32'(counter_out), 32'd0);
        check("midcount_reset_wrap", 32'(wrap_pulse), 32'd0);

`ifndef COUNTER_PRESCALE_EN
        //  ld lv  en dir st lim sat | cnt wrap max min
        add(0, 0,   1, 1, 3, 9,   0,   3,  0, 0, 0);
        add(0, 0,   1, 1, 3, 9,   0,   6,  0, 0, 0);
        add(0, 0,   1, 1, 3, 9,   0,   9,  0, 1, 0);
        add(0, 0,   1, 1, 3, 9,   0,   2,  1, 0, 0);
        add(1, 2,   0, 0, 4, 9,   0,   2,  0, 0, 0);
        add(0, 0,   1, 0, 4, 9,   0,   8,  1, 0, 0);
        add(1, 2,   0, 0, 4, 9,   1,   2,  0, 0, 0);
        add(0, 0,   1, 0, 4, 9,   1,   0,  0, 0, 1);
        add(0, 0,   1, 0, 4, 9,   1,   0,  0, 0, 1);
        add(1, 8,   0, 1, 4, 9,   1,   8,  0, 0, 0);
        add(0, 0,   1, 1, 4, 9,   1,   9,  0, 1, 0);
        add(0, 0,   1, 1, 4, 9,   1,   9,  0, 1, 0);
        add(1, 200, 0, 1, 1, 150, 0, 150,  0, 1, 0);
        add(0, 0,   0, 1, 1, 100, 0, 100,  0, 1, 0);
        add(1, 50,  1, 1, 3, 100, 0,  50,  0, 0, 0);
        add(1, 55,  0, 1, 3, 100, 0,  55,  0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 3, 100, 0, 55, 0, 0, 0);
        add(0, 0,   1, 1, 0, 100, 0,  55,  0, 0, 0);
        add(0, 0,   1, 0, 0, 100, 0,  55,  0, 0, 0);
        add(0, 0,   1, 1, 5, 0,   0,   0,  0, 1, 1);
        add(0, 0,   1, 1, 5, 0,   0,   0,  0, 1, 1);
        add(0, 0,   1, 0, 5, 0,   0,   0,  0, 1, 1);

        for (int i = 0; i < vec_q.size(); i++) begin
            drive(vec_q[i].ld, vec_q[i].lv, vec_q[i].en, vec_q[i].dir,
                  vec_q[i].st, vec_q[i].lim, vec_q[i].sat);
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(counter_out), 32'(vec_q[i].exp_cnt));
            check($sformatf("vec%0d_wrap", i), 32'(wrap_pulse), 32'(vec_q[i].exp_wrap));
            check($sformatf("vec%0d_at_max", i), 32'(at_max), 32'(vec_q[i].exp_max));
            check($sformatf("vec%0d_at_min", i), 32'(at_min), 32'(vec_q[i].exp_min));
        end
`else
        // Counter already 0 and prescaler cleared by the reset above.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 8'd255, 1'b0);
            tick();
            check($sformatf("ps_cycle%0d", i), 32'(counter_out), (i >= 8) ? 32'd2 : ((i >= 4) ? 32'd1 : 32'd0));
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive((i == 2) ? 1'b1 : 1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 8'd255, 1'b0);
            tick();
            check($sformatf("ps_load_cycle%0d", i), 32'(counter_out), (i == 6) ? 32'd1 : 32'd0);
        end
`endif

        // Randomized run against the reference model.
        rst = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b1, 4'd0, 8'd9, 1'b0);
        tick();
        rst = 1'b1;
        m_cnt = 0;
        m_ps  = 0;
        m_wrap = 0;
        begin
            int lim_r;
            lim_r = 9;
            for (int i = 0; i < 2000; i++) begin
                int r_r, ld_r, lv_r, en_r, dir_r, st_r, sat_r;
                if ($urandom_range(0, 15) == 0)
                    lim_r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
                r_r   = ($urandom_range(0, 99) == 0) ? 0 : 1;
                ld_r  = ($urandom_range(0, 9) == 0) ? 1 : 0;
                lv_r  = $urandom_range(0, 255);
                en_r  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                dir_r = $urandom_range(0, 1);
                st_r  = $urandom_range(0, 15);
                sat_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
                rst = r_r[0];
                drive(ld_r[0], lv_r[7:0], en_r[0], dir_r[0], st_r[3:0], lim_r[7:0], sat_r[0]);
                model_step(r_r, ld_r, lv_r, en_r, dir_r, st_r, lim_r, sat_r);
                tick();
                check($sformatf("rand%0d_cnt", i), 32'(counter_out), 32'(m_cnt));
                check($sformatf("rand%0d_wrap", i), 32'(wrap_pulse), 32'(m_wrap));
                check($sformatf("rand%0d_at_max", i), 32'(at_max), (m_cnt == lim_r) ? 32'd1 : 32'd0);
                check($sformatf("rand%0d_at_min", i), 32'(at_min), (m_cnt == 0) ? 32'd1 : 32'd0);
            end
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
